activation_unit: RTL and testbench



---
 rtl/activation_unit_pkg.sv | 59 +++++
 rtl/activation_unit_sigmoid_rom.sv | 70 +++++++
 rtl/activation_unit.sv | 98 +++++++++
 tb/tb_activation_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/activation_unit_pkg.sv
// Shared fixed-point helpers, mode names and the sigmoid table generator for activation_unit.
package activation_unit_pkg;

    localparam string ACT_RELU         = "relu";
    localparam string ACT_SIGMOID_FULL = "sigmoid_full";
    localparam string ACT_SIGMOID_HALF = "sigmoid_half";

    // Fractional bits of the Q(wiw).(dw-wiw) data format.
    function automatic int frac_of(input int dw, input int wiw);
        return dw - wiw;
    endfunction

    // Fixed-point representation of 1.0.
    function automatic int one_of(input int dw, input int wiw);
        return 1 << (dw - wiw);
    endfunction

    // e^y via a Taylor series on y/256, then squared eight times. Only
    // multiply/divide are used so the table builds at elaboration.
    function automatic real exp_series(input real y);
        real t;
        real term;
        real acc;
        real nr;
        t    = y / 256.0;
        term = 1.0;
        acc  = 1.0;
        nr   = 1.0;
        for (int n = 0; n < 12; n++) begin
            term = term * t / nr;
            acc  = acc + term;
            nr   = nr + 1.0;
        end
        for (int i = 0; i < 8; i++) begin
            acc = acc * acc;
        end
        return acc;
    endfunction

    // T(v) = min(round_half_up(one / (1 + e^-v)), one - 1), v = x_val / 2^x_frac.
    function automatic int sigmoid_entry(input int x_val, input int x_frac, input int one);
        real scale;
        real v;
        real r;
        int  e;
        scale = 1.0;
        for (int i = 0; i < x_frac; i++) begin
            scale = scale * 2.0;
        end
        v = $itor(x_val) / scale;
        r = $itor(one) / (1.0 + exp_series(-v));
        e = $rtoi(r + 0.5);
        if (e > one - 1) begin
            e = one - 1;
        end
        return e;
    endfunction

endpackage

// File: rtl/activation_unit_sigmoid_rom.sv
// Sigmoid lookup with a registered single-port read. HALF=1 stores only v >= 0
// and mirrors negative inputs as ONE - T(|v|).
module act_sigmoid_rom
    import activation_unit_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_INT_WIDTH = 4,
    parameter int SIGMOID_SIZE     = 10,
    parameter bit HALF             = 1'b0
) (
    input  logic                    clk,
    input  logic                    sign_flag,
    input  logic [SIGMOID_SIZE-1:0] x,
    output logic [DATA_WIDTH-1:0]   result
);

    localparam int XF  = SIGMOID_SIZE - WEIGHT_INT_WIDTH;
    localparam int ONE = one_of(DATA_WIDTH, WEIGHT_INT_WIDTH);

    logic [DATA_WIDTH-1:0] result_d;
    logic [DATA_WIDTH-1:0] result_q;

    if (HALF) begin : g_half
        localparam int DEPTH = 2 ** (SIGMOID_SIZE - 1);
        logic [DATA_WIDTH-1:0]   rom [DEPTH];
        logic [SIGMOID_SIZE-2:0] idx;
        logic [DATA_WIDTH-1:0]   entry;

        for (genvar a = 0; a < DEPTH; a++) begin : g_rom
            assign rom[a] = DATA_WIDTH'(sigmoid_entry(a, XF, ONE));
        end

        // |x| with the most-negative code clamped to the last entry, then mirror on sign.
        always_comb begin
            idx = x[SIGMOID_SIZE-2:0];
            if (x == {1'b1, {(SIGMOID_SIZE-1){1'b0}}}) begin
                idx = '1;
            end else if (x[SIGMOID_SIZE-1]) begin
                idx = ~x[SIGMOID_SIZE-2:0] + (SIGMOID_SIZE-1)'(1);
            end
            entry    = rom[idx];
            result_d = sign_flag ? (DATA_WIDTH'(ONE) - entry) : entry;
        end
    end else begin : g_full
        localparam int DEPTH = 2 ** SIGMOID_SIZE;
        logic [DATA_WIDTH-1:0]   rom [DEPTH];
        logic [SIGMOID_SIZE-1:0] addr;
        logic                    sign_unused;

        for (genvar a = 0; a < DEPTH; a++) begin : g_rom
            assign rom[a] = DATA_WIDTH'(sigmoid_entry(a - 2 ** (SIGMOID_SIZE - 1), XF, ONE));
        end

        assign sign_unused = sign_flag;

        // Inverting the MSB maps signed x onto an unsigned table address.
        always_comb begin
            addr     = {~x[SIGMOID_SIZE-1], x[SIGMOID_SIZE-2:0]};
            result_d = rom[addr];
        end
    end

    // Registered table read.
    always_ff @(posedge clk) begin
        result_q <= result_d;
    end

    assign result = result_q;

endmodule

// File: rtl/activation_unit.sv
// Registered activation stage after a neuron MAC: ReLU, full/half sigmoid table, or passthrough.
module activation_unit
    import activation_unit_pkg::*;
#(
    parameter int    DATA_WIDTH       = 16,
    parameter int    WEIGHT_INT_WIDTH = 4,
    parameter int    SIGMOID_SIZE     = 10,
    parameter string ACT_TYPE         = "relu"
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [2*DATA_WIDTH-1:0] sum,
    output logic        [DATA_WIDTH-1:0]   out,
    output logic                           out_valid
);

    localparam bit IS_RELU  = (ACT_TYPE == ACT_RELU);
    localparam bit IS_SFULL = (ACT_TYPE == ACT_SIGMOID_FULL);
    localparam bit IS_SHALF = (ACT_TYPE == ACT_SIGMOID_HALF);
    localparam int MSB      = 2 * DATA_WIDTH - 1;
    localparam int TOP      = MSB - WEIGHT_INT_WIDTH;

    logic out_valid_d;
    logic out_valid_q;
    logic sum_unused;

    // Each mode uses a different window of sum.
    assign sum_unused = ^sum;

    // Valid is in_valid delayed one cycle; reset wins.
    always_comb begin
        out_valid_d = rst ? 1'b0 : in_valid;
    end

    // Valid pipeline register.
    always_ff @(posedge clk) begin
        out_valid_q <= out_valid_d;
    end

    assign out_valid = out_valid_q;

    if (IS_SFULL || IS_SHALF) begin : g_sigmoid
        logic [DATA_WIDTH-1:0] rom_result;
        logic                  clear_d;
        logic                  clear_q;

        act_sigmoid_rom #(
            .DATA_WIDTH       (DATA_WIDTH),
            .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
            .SIGMOID_SIZE     (SIGMOID_SIZE),
            .HALF             (IS_SHALF)
        ) u_rom (
            .clk       (clk),
            .sign_flag (sum[MSB]),
            .x         (sum[TOP -: SIGMOID_SIZE]),
            .result    (rom_result)
        );

        // The table register has no reset, so a reset edge masks its output for that cycle.
        always_comb begin
            clear_d = rst;
        end

        // Reset mask register.
        always_ff @(posedge clk) begin
            clear_q <= clear_d;
        end

        assign out = clear_q ? '0 : rom_result;
    end else begin : g_inline
        logic [DATA_WIDTH-1:0] out_d;
        logic [DATA_WIDTH-1:0] out_q;

        // Passthrough takes the aligned slice; ReLU clamps negatives and saturates overflow.
        always_comb begin
            out_d = sum[TOP -: DATA_WIDTH];
            if (IS_RELU) begin
                if (sum[MSB]) begin
                    out_d = '0;
                end else if (|sum[MSB -: WEIGHT_INT_WIDTH + 1]) begin
                    out_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end
            end
            if (rst) begin
                out_d = '0;
            end
        end

        // Output register.
        always_ff @(posedge clk) begin
            out_q <= out_d;
        end

        assign out = out_q;
    end

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench: one instance per activation mode on shared inputs, scoreboard per instance.
module tb_activation_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] sum;

    logic [15:0] out_relu, out_full, out_half, out_pass;
    logic        ov_relu, ov_full, ov_half, ov_pass;

    int checks = 0;
    int errors = 0;

    logic [15:0] q_relu[$];
    logic [15:0] q_full[$];
    logic [15:0] q_half[$];
    logic [15:0] q_pass[$];

    logic mon_en        = 1'b0;
    logic exp_out_valid = 1'b0;

    activation_unit #(.ACT_TYPE("relu")) dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_relu), .out_valid(ov_relu));
    activation_unit #(.ACT_TYPE("sigmoid_full")) dut_full (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_full), .out_valid(ov_full));
    activation_unit #(.ACT_TYPE("sigmoid_half")) dut_half (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_half), .out_valid(ov_half));
    activation_unit #(.ACT_TYPE("none")) dut_pass (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_pass), .out_valid(ov_pass));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int t_entry(input int xi);
        real r;
        int  e;
        r = 4096.0 / (1.0 + $exp(-($itor(xi) / 64.0)));
        e = $rtoi(r + 0.5);
        if (e > 4095) e = 4095;
        return e;
    endfunction

    function automatic logic [15:0] m_relu(input logic [31:0] s);
        if (s[31]) return 16'h0000;
        if (s[31:27] != 5'd0) return 16'h7FFF;
        return s[27:12];
    endfunction

    function automatic logic [15:0] m_full(input logic [31:0] s);
        logic signed [9:0] x;
        x = s[27:18];
        return 16'(t_entry(int'(x)));
    endfunction

    function automatic logic [15:0] m_half(input logic [31:0] s);
        logic signed [9:0] x;
        int xi;
        int k;
        int e;
        x  = s[27:18];
        xi = int'(x);
        k  = (xi < 0) ? -xi : xi;
        if (k > 511) k = 511;
        e = t_entry(k);
        return s[31] ? 16'(4096 - e) : 16'(e);
    endfunction

    // Drive one cycle of inputs, record expectations, advance past the edge.
    task automatic step(input logic v, input logic [31:0] s, input logic r);
        in_valid = v;
        sum      = s;
        rst      = r;
        if (v && !r) begin
            q_relu.push_back(m_relu(s));
            q_full.push_back(m_full(s));
            q_half.push_back(m_half(s));
            q_pass.push_back(s[27:12]);
        end
        @(posedge clk);
        #1;
        exp_out_valid = v && !r;
    endtask

    // Scoreboard consumer: check valid every cycle, pop and compare data when valid.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ({ov_relu, ov_full, ov_half, ov_pass} !== {4{exp_out_valid}}) begin
                errors++;
                $display("FAIL out_valid got %b%b%b%b expected %b", ov_relu, ov_full, ov_half, ov_pass, exp_out_valid);
            end
            if (exp_out_valid) begin
                checks++;
                if (q_relu.size() == 0 || q_full.size() == 0 || q_half.size() == 0 || q_pass.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow got empty queue expected pending sample");
                end else begin
                    logic [15:0] e_r, e_f, e_h, e_p;
                    e_r = q_relu.pop_front();
                    e_f = q_full.pop_front();
                    e_h = q_half.pop_front();
                    e_p = q_pass.pop_front();
                    if (out_relu !== e_r) begin
                        errors++;
                        $display("FAIL relu got %h expected %h", out_relu, e_r);
                    end
                    checks++;
                    if (out_full !== e_f) begin
                        errors++;
                        $display("FAIL sigmoid_full got %0d expected %0d", out_full, e_f);
                    end
                    checks++;
                    if (out_half !== e_h) begin
                        errors++;
                        $display("FAIL sigmoid_half got %0d expected %0d", out_half, e_h);
                    end
                    checks++;
                    if (out_pass !== e_p) begin
                        errors++;
                        $display("FAIL passthrough got %h expected %h", out_pass, e_p);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        step(1'b1, 32'h0180_0000, 1'b1);
        checks++;
        if ({out_relu, out_full, out_half, out_pass} !== 64'd0) begin
            errors++;
            $display("FAIL reset_out got %h %h %h %h expected 0", out_relu, out_full, out_half, out_pass);
        end
        checks++;
        if ({ov_relu, ov_full, ov_half, ov_pass} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid got %b%b%b%b expected 0000", ov_relu, ov_full, ov_half, ov_pass);
        end
        mon_en = 1'b1;
        step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_relu();
        logic [31:0] vec [6];
        vec = '{32'h0180_0000, 32'hFFFF_F000, 32'h1000_0000, 32'h0800_0000, 32'h07FF_FFFF, 32'h0000_0000};
        foreach (vec[i]) step(1'b1, vec[i], 1'b0);
        step(1'b0, 32'h0180_0000, 1'b0);
        step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_sigmoid();
        logic [31:0] vec [7];
        vec = '{32'h0000_0000, 32'h0100_0000, 32'hFF00_0000, 32'hF800_0000,
                32'h07FC_0000, 32'h0040_0000, 32'hFFC0_0000};
        foreach (vec[i]) begin
            step(1'b1, vec[i], 1'b0);
            step(1'b0, 32'd0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom(), 1'b0);
        end
        step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 32'h0100_0000, 1'b0);
        step(1'b1, 32'h0180_0000, 1'b0);
        step(1'b1, 32'h0040_0000, 1'b1);
        checks++;
        if ({out_relu, out_full, out_half, out_pass} !== 64'd0) begin
            errors++;
            $display("FAIL midstream_reset_out got %h %h %h %h expected 0", out_relu, out_full, out_half, out_pass);
        end
        checks++;
        if ({ov_relu, ov_full, ov_half, ov_pass} !== 4'b0000) begin
            errors++;
            $display("FAIL midstream_reset_valid got %b%b%b%b expected 0000", ov_relu, ov_full, ov_half, ov_pass);
        end
        step(1'b1, 32'hFF00_0000, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sum      = '0;
        test_reset();
        test_relu();
        test_sigmoid();
        test_back_to_back();
        test_reset_midstream();
        step(1'b0, 32'd0, 1'b0);
        checks++;
        if (q_relu.size() + q_full.size() + q_half.size() + q_pass.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0",
                     q_relu.size() + q_full.size() + q_half.size() + q_pass.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
